// File: rtl/bus_share_arbiter_if.sv
// Bundle of master-side command/response signals and the shared bus
// between the arbiter (slave modport) and its environment (master modport).
interface bus_share_arbiter_if #(
    parameter int NumReq        = 2,
    parameter int address_width = 16,
    parameter int data_width    = 8
);
    // Handshake: a master raises req_i with a stable we/addr/wdata and keeps
    // them until the arbiter returns a one-cycle ack_o on that master's bit;
    // the command is only sampled while the arbiter is idle, and a request
    // that has been issued on the bus always completes with an ack.
    logic [NumReq-1:0]               req_i;
    logic [NumReq-1:0]               we_i;
    logic [NumReq*address_width-1:0] addr_i;
    logic [NumReq*data_width-1:0]    wdata_i;
    logic [NumReq-1:0]               lock_i;
    logic [NumReq-1:0]               ack_o;
    logic [data_width-1:0]           rdata_o;
    logic [NumReq-1:0]               gnt_o;
    logic                            bus_en_o;
    logic                            bus_we_o;
    logic [address_width-1:0]        bus_addr_o;
    logic [data_width-1:0]           bus_wdata_o;
    logic [data_width-1:0]           bus_rdata_i;

    modport master (
        output req_i, we_i, addr_i, wdata_i, lock_i, bus_rdata_i,
        input  ack_o, rdata_o, gnt_o, bus_en_o, bus_we_o, bus_addr_o, bus_wdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, lock_i, bus_rdata_i,
        output ack_o, rdata_o, gnt_o, bus_en_o, bus_we_o, bus_addr_o, bus_wdata_o
    );
endinterface

// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter that shares one 6502-side bus between NumReq masters,
// issuing one registered bus cycle per grant with optional per-master lock.
module bus_share_arbiter #(
    parameter int NumReq        = 2,
    parameter int address_width = 16,
    parameter int data_width    = 8,
    parameter int ReadLatency   = 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    bus_share_arbiter_if.slave  bus,
    output logic [1:0]          state_dbg
);
    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t                   state_q, state_d;
    logic [IdxW-1:0]          last_q, last_d;
    logic [IdxW-1:0]          owner_q, owner_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [NumReq-1:0]        gnt_q, gnt_d;
    logic [NumReq-1:0]        ack_q, ack_d;
    logic                     en_q, en_d;
    logic                     we_q, we_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [data_width-1:0]    wdata_q, wdata_d;
    logic [data_width-1:0]    rdata_q, rdata_d;

    logic [IdxW:0]            sel;
    logic                     sel_valid;
    logic [IdxW-1:0]          sel_idx;

    // Locked previous owner keeps the bus; otherwise scan from last+1 upward.
    function automatic logic [IdxW:0] pick(input logic [NumReq-1:0] req,
                                           input logic [NumReq-1:0] lock,
                                           input logic [IdxW-1:0]   last);
        logic [IdxW-1:0] cand;
        logic            found;
        pick  = '0;
        found = 1'b0;
        if (lock[last] && req[last]) begin
            pick  = {1'b1, last};
            found = 1'b1;
        end
        for (int k = 1; k <= NumReq; k++) begin
            cand = IdxW'((int'(last) + k) % NumReq);
            if (!found && req[cand]) begin
                pick  = {1'b1, cand};
                found = 1'b1;
            end
        end
    endfunction

    always_comb begin
        sel       = pick(bus.req_i, bus.lock_i, last_q);
        sel_valid = sel[IdxW];
        sel_idx   = sel[IdxW-1:0];
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        en_d    = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d          = ISSUE;
                    owner_d          = sel_idx;
                    gnt_d            = '0;
                    gnt_d[sel_idx]   = 1'b1;
                    en_d             = 1'b1;
                    we_d             = bus.we_i[sel_idx];
                    addr_d           = bus.addr_i[int'(sel_idx)*address_width +: address_width];
                    wdata_d          = bus.wdata_i[int'(sel_idx)*data_width +: data_width];
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CntW'(ReadLatency - 1);
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // Captured for writes too; the value is simply meaningless then.
                    rdata_d = bus.bus_rdata_i;
                    ack_d   = gnt_q;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = '0;
                last_d  = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            last_q  <= IdxW'(NumReq - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.ack_o       = ack_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.bus_en_o    = en_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_bus_share_arbiter.sv
// Bench for bus_share_arbiter: transaction-timeline model checked every cycle
// on a ReadLatency=1 instance, plus directed checks on a ReadLatency=3 instance.
module tb_bus_share_arbiter;
    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int R1 = 1;
    localparam int R3 = 3;

    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b0;
    logic [1:0] state1, state3;
    logic [N-1:0] ack_prev = '0;
    logic [N-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    logic [7:0] slave_mem [256];
    logic [7:0] model_mem [256];

    // ---------------- clock / reset / DUTs ----------------
    always #5 clk_i = ~clk_i;

    bus_share_arbiter_if #(.NumReq(N), .address_width(AW), .data_width(DW)) bus1();
    bus_share_arbiter_if #(.NumReq(N), .address_width(AW), .data_width(DW)) bus3();

    bus_share_arbiter #(.NumReq(N), .address_width(AW), .data_width(DW), .ReadLatency(R1)) u_dut1 (
        .clk_i(clk_i), .reset_i(reset_i), .bus(bus1), .state_dbg(state1)
    );
    bus_share_arbiter #(.NumReq(N), .address_width(AW), .data_width(DW), .ReadLatency(R3)) u_dut3 (
        .clk_i(clk_i), .reset_i(reset_i), .bus(bus3), .state_dbg(state3)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cmd(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus1.we_i[m]            = we;
        bus1.addr_i[m*AW +: AW] = a;
        bus1.wdata_i[m*DW +: DW] = d;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return {8'($urandom), 8'($urandom_range(0, 15))};
    endfunction

    function automatic int pick(input logic [N-1:0] req, input logic [N-1:0] lock, input int last);
        if (lock[last] && req[last]) return last;
        for (int k = 1; k <= N; k++)
            if (req[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // ---------------- slave for the latency-1 instance ----------------
    initial begin : slave1
        int         pend;
        logic       armed;
        logic [7:0] pdata;
        pend  = 0;
        armed = 1'b0;
        pdata = '0;
        bus1.bus_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                armed = 1'b0;
                pend  = 0;
            end
            if (pend > 0) pend--;
            if (armed && pend == 0) begin
                bus1.bus_rdata_i = pdata;
                armed = 1'b0;
            end else begin
                bus1.bus_rdata_i = 8'($urandom);
            end
            if (reset_i && bus1.bus_en_o) begin
                pend  = R1;
                armed = 1'b1;
                pdata = slave_mem[bus1.bus_addr_o[7:0]];
                if (bus1.bus_we_o) slave_mem[bus1.bus_addr_o[7:0]] = bus1.bus_wdata_o;
            end
        end
    end

    // ---------------- model + per-cycle compare ----------------
    // Timeline model: a granted transaction occupies phases 0 (strobe)
    // .. R1+1 (ack); the cycle after the ack phase is idle again.
    initial begin : compare
        int         m_t, m_owner, m_last, w;
        logic       m_we, m_known;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, m_rdata;
        logic [N-1:0]  e_gnt, e_ack;
        m_t = -1; m_owner = 0; m_last = N - 1;
        m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_known = 1'b1;
        forever begin
            @(negedge clk_i);
            ack_prev = bus1.ack_o;
            if (!reset_i) begin
                m_t = -1; m_last = N - 1;
                m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_known = 1'b1;
                check("rst_gnt", bus1.gnt_o, 0);
                check("rst_ack", bus1.ack_o, 0);
                check("rst_en", bus1.bus_en_o, 0);
                check("rst_we", bus1.bus_we_o, 0);
                check("rst_addr", bus1.bus_addr_o, 0);
                check("rst_wdata", bus1.bus_wdata_o, 0);
                check("rst_rdata", bus1.rdata_o, 0);
            end else begin
                e_gnt = (m_t >= 0) ? N'(1 << m_owner) : '0;
                e_ack = (m_t == R1 + 1) ? N'(1 << m_owner) : '0;
                if (m_t == R1 + 1) begin
                    m_known = !m_we;
                    if (!m_we) m_rdata = model_mem[m_addr[7:0]];
                end
                check("gnt", bus1.gnt_o, e_gnt);
                check("ack", bus1.ack_o, e_ack);
                check("bus_en", bus1.bus_en_o, m_t == 0);
                check("bus_we", bus1.bus_we_o, m_we);
                check("bus_addr", bus1.bus_addr_o, m_addr);
                check("bus_wdata", bus1.bus_wdata_o, m_wdata);
                if (m_known) check("rdata", bus1.rdata_o, m_rdata);
                if (m_t == R1 + 1) begin
                    m_last = m_owner;
                    m_t    = -1;
                end else if (m_t >= 0) begin
                    m_t++;
                end else begin
                    w = pick(bus1.req_i, bus1.lock_i, m_last);
                    if (w >= 0) begin
                        m_owner = w;
                        m_t     = 0;
                        m_we    = bus1.we_i[w];
                        m_addr  = bus1.addr_i[w*AW +: AW];
                        m_wdata = bus1.wdata_i[w*DW +: DW];
                        if (m_we) model_mem[m_addr[7:0]] = m_wdata;
                    end
                end
            end
        end
    end

    // Consume exp_q in ack order; masters re-request right after each ack.
    task automatic run_sequence(input string name, input int unlock_after, input int spacing);
        int c_last, n;
        logic [N-1:0] a, e;
        c_last = -1;
        n = 0;
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            @(negedge clk_i);
            a = bus1.ack_o;
            if (a != '0) begin
                e = exp_q.pop_front();
                check({name, "_owner"}, a, e);
                if (spacing > 0 && c_last >= 0) check({name, "_spacing"}, c - c_last, spacing);
                c_last = c;
                n++;
                tick();
                if (n == unlock_after) bus1.lock_i = '0;
                if (exp_q.size() == 0) bus1.req_i = '0;
                else set_cmd(a[1] ? 1 : 0, 1'b0, rand_addr(), 8'h00);
            end
        end
        if (exp_q.size() != 0) begin
            check({name, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic test_latency3();
        tick();
        bus3.we_i = '0;
        bus3.addr_i[0 +: AW] = 16'h00FF;
        bus3.req_i[0] = 1'b1;
        bus3.bus_rdata_i = 8'($urandom_range(0, 59));
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus3.bus_rdata_i = (k == 4) ? 8'h3C : 8'($urandom_range(0, 59));
            if (k == 6) bus3.req_i = '0;
            @(negedge clk_i);
            check("l3_en", bus3.bus_en_o, k == 1);
            if (k == 1) check("l3_addr", bus3.bus_addr_o, 16'h00FF);
            check("l3_gnt", bus3.gnt_o, (k <= 5) ? 2'b01 : 2'b00);
            check("l3_ack", bus3.ack_o, (k == 5) ? 2'b01 : 2'b00);
            if (k == 5) check("l3_rdata", bus3.rdata_o, 8'h3C);
        end
    endtask

    // ---------------- main stimulus ----------------
    initial begin : main
        logic done, first;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 8'(i * 7 + 3);
            model_mem[i] = 8'(i * 7 + 3);
        end
        slave_mem[8'h34] = 8'hA5;
        model_mem[8'h34] = 8'hA5;
        bus1.req_i = '0; bus1.we_i = '0; bus1.addr_i = '0; bus1.wdata_i = '0; bus1.lock_i = '0;
        bus3.req_i = '0; bus3.we_i = '0; bus3.addr_i = '0; bus3.wdata_i = '0; bus3.lock_i = '0;
        bus3.bus_rdata_i = '0;
        repeat (3) tick();
        reset_i = 1'b1;

        // single read by master 1
        tick();
        set_cmd(1, 1'b0, 16'h1234, 8'h00);
        bus1.req_i[1] = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rd_en", bus1.bus_en_o, 1);
        check("rd_addr", bus1.bus_addr_o, 16'h1234);
        check("rd_we", bus1.bus_we_o, 0);
        check("rd_gnt", bus1.gnt_o, 2'b10);
        @(negedge clk_i);
        check("rd_en_off", bus1.bus_en_o, 0);
        @(negedge clk_i);
        check("rd_ack", bus1.ack_o, 2'b10);
        check("rd_data", bus1.rdata_o, 8'hA5);
        tick();
        bus1.req_i = '0;

        // contention: alternate grants, 4-cycle ack spacing
        tick();
        set_cmd(0, 1'b0, rand_addr(), 8'h00);
        set_cmd(1, 1'b0, rand_addr(), 8'h00);
        bus1.req_i = 2'b11;
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
        run_sequence("cont", 0, 4);

        // write by master 0
        tick();
        set_cmd(0, 1'b1, 16'h0200, 8'h5A);
        bus1.req_i[0] = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("wr_en", bus1.bus_en_o, 1);
        check("wr_we", bus1.bus_we_o, 1);
        check("wr_wdata", bus1.bus_wdata_o, 8'h5A);
        check("wr_addr", bus1.bus_addr_o, 16'h0200);
        @(negedge clk_i);
        check("wr_en_off", bus1.bus_en_o, 0);
        @(negedge clk_i);
        check("wr_ack", bus1.ack_o, 2'b01);
        tick();
        bus1.req_i = '0;
        @(negedge clk_i);
        check("wr_no_second_a", bus1.bus_en_o, 0);
        @(negedge clk_i);
        check("wr_no_second_b", bus1.bus_en_o, 0);

        // lock: master 0 keeps the bus three times, master 1 wins after unlock
        tick();
        set_cmd(0, 1'b0, rand_addr(), 8'h00);
        set_cmd(1, 1'b0, rand_addr(), 8'h00);
        bus1.lock_i = 2'b01;
        bus1.req_i = 2'b11;
        repeat (3) exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        run_sequence("lock", 3, 0);

        // async reset in the WAIT cycle
        tick();
        set_cmd(0, 1'b0, 16'h0042, 8'h00);
        bus1.req_i[0] = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        #1;
        check("arst_en", bus1.bus_en_o, 0);
        check("arst_gnt", bus1.gnt_o, 0);
        check("arst_ack", bus1.ack_o, 0);
        tick();
        reset_i = 1'b1;
        done = 1'b0;
        first = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk_i);
            if (!first && bus1.gnt_o != '0) begin
                check("post_rst_first_gnt", bus1.gnt_o, 2'b01);
                first = 1'b1;
            end
            if (bus1.ack_o != '0) begin
                check("post_rst_ack", bus1.ack_o, 2'b01);
                check("post_rst_rdata", bus1.rdata_o, 8'hD1);
                done = 1'b1;
                tick();
                bus1.req_i = '0;
            end
        end
        check("post_rst_done", done, 1);

        test_latency3();

        // randomized traffic with locks and occasional withdrawals
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int m = 0; m < N; m++) begin
                if (bus1.req_i[m]) begin
                    if (ack_prev[m]) begin
                        if ($urandom_range(0, 1) == 1)
                            set_cmd(m, 1'($urandom), rand_addr(), 8'($urandom));
                        else
                            bus1.req_i[m] = 1'b0;
                    end else if ($urandom_range(0, 40) == 0) begin
                        bus1.req_i[m] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    set_cmd(m, 1'($urandom), rand_addr(), 8'($urandom));
                    bus1.req_i[m] = 1'b1;
                end
                bus1.lock_i[m] = ($urandom_range(0, 3) == 0);
            end
        end
        tick();
        bus1.req_i = '0;
        bus1.lock_i = '0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_share_arbiter.md
Name: bus_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 6502-side memory/peripheral bus between NumReq masters, e.g. CPU core and UART debug loader.
- Sits between the masters and the shared address/data decode inside the 6502 subsystem.
- Issues one registered bus cycle per grant, waits the slave's fixed read latency, and returns read data with a one-cycle acknowledge.
- Supports per-master lock for atomic read-modify-write sequences.

Parameters:
- NumReq, 2, number of requesting masters; legal range 2..4.
- address_width, 16, bus address width.
- data_width, 8, bus data width.
- ReadLatency, 1, cycles from bus_en_o high to bus_rdata_i valid; legal range 1..7.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- req_i  in  NumReq  per-master request; held high with stable cmd until ack
- we_i  in  NumReq  per-master write enable
- addr_i  in  NumReq*address_width  per-master address, packed, master 0 in LSBs
- wdata_i  in  NumReq*data_width  per-master write data, packed
- lock_i  in  NumReq  master keeps priority while high
- ack_o  out  NumReq  one-cycle completion pulse to the granted master
- rdata_o  out  data_width  read data, valid when any ack_o bit is high
- gnt_o  out  NumReq  one-hot current owner; all zero when idle
- bus_en_o  out  1  one-cycle bus strobe
- bus_we_o  out  1  write qualifier for bus_en_o
- bus_addr_o  out  address_width  bus address
- bus_wdata_o  out  data_width  bus write data
- bus_rdata_i  in  data_width  slave read data

Behaviour:
- Reset (reset_i low, asynchronous):
  - State goes to IDLE.
  - gnt_o, ack_o, bus_en_o, bus_we_o = 0; bus_addr_o, bus_wdata_o, rdata_o = 0.
  - Round-robin pointer last = NumReq-1, so master 0 wins the first contest.
  - Latency counter = 0.
- Reset asserted mid-transaction aborts it silently: no ack, bus_en_o drops immediately.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req_i is high, select the winner and go to ISSUE. gnt_o is one-hot from the ISSUE cycle on.
  - Winner selection: if lock_i[last] and req_i[last] are both high, the winner is last. Otherwise, scan indices last+1, last+2, ... modulo NumReq; the first index with req_i high wins.
  - Latch the winner's we, addr and wdata into the bus_* registers.
- ISSUE: bus_en_o = 1 for exactly one cycle; bus_we_o = latched we. Load counter = ReadLatency-1; go to WAIT.
- WAIT:
  - bus_en_o = 0; bus_addr_o, bus_we_o and bus_wdata_o hold their values.
  - Counter decrements each cycle.
  - When the counter is 0, capture bus_rdata_i into rdata_o and go to ACK.
  - For writes, rdata_o is still updated; its value is don't-care.
- ACK:
  - ack_o[winner] = 1 for one cycle; last := winner.
  - gnt_o clears on leaving ACK; next state is always IDLE.
- Latency: req_i seen high in IDLE cycle T gives bus_en_o at T+1, rdata sampled in cycle T+1+ReadLatency, ack_o at T+2+ReadLatency. Minimum spacing between transactions is ReadLatency+3 cycles.
- Protocol rules on masters:
  - Hold req/we/addr/wdata stable until ack.
  - Drop req_i in the cycle after ack, unless a new request follows.
- Protocol responses from the arbiter:
  - A req_i deassertion after ISSUE does not cancel the transaction; ack is still pulsed.
  - Command inputs are sampled only in IDLE; changes during ISSUE/WAIT/ACK are ignored.
- Simultaneous requests: exactly one grant; the others wait in IDLE, with no loss and no duplicate ack.
- Lock: it affects only the winner selection in IDLE. If the locked master does not request, normal round-robin applies.
- Invariant: gnt_o and ack_o are never multi-hot.

Test Plan:
- Single read: NumReq=2, ReadLatency=1, master 1 reads 0x1234 with slave returning 0xA5 → bus_en_o high 1 cycle at T+1 with bus_addr_o=0x1234, bus_we_o=0; ack_o=2'b10 at T+3; rdata_o=0xA5.
- Write: master 0 writes 0x5A to 0x0200 → bus_en_o=1, bus_we_o=1, bus_wdata_o=0x5A for one cycle; ack_o=2'b01 at T+3; no second strobe.
- Contention: both masters request continuously for 6 transactions → grants alternate 0,1,0,1,0,1; ack spacing exactly 4 cycles (ReadLatency=1).
- Lock: master 0 holds lock_i[0]=1 across 3 back-to-back requests while master 1 requests → master 0 wins all 3. Master 1 wins the first contest after lock_i[0] drops.
- ReadLatency=3: read from 0x00FF, slave drives 0x3C only in cycle T+4 → rdata_o=0x3C, ack at T+5.
- Async reset mid-WAIT: reset_i low for 1 cycle during WAIT → bus_en_o/gnt_o/ack_o = 0 immediately, no ack pulse. After release, a pending master 0 request completes normally with a first grant to master 0.
